// File: rtl/cp0_pkg.sv
// ============================================================================
// Module   : cp0_pkg
// Purpose  : CP0 register indices, SR/Cause bit positions and PRId default.
// Revision : 1.0
// ============================================================================
`default_nettype none

package cp0_pkg;

  localparam int          C_XLEN          = 32;

  localparam logic [4:0]  C_REG_COUNT     = 5'd9;
  localparam logic [4:0]  C_REG_COMPARE   = 5'd11;
  localparam logic [4:0]  C_REG_SR        = 5'd12;
  localparam logic [4:0]  C_REG_CAUSE     = 5'd13;
  localparam logic [4:0]  C_REG_EPC       = 5'd14;
  localparam logic [4:0]  C_REG_PRID      = 5'd15;

  localparam int          C_BIT_IE        = 0;
  localparam int          C_BIT_EXL       = 1;
  localparam int          C_IM_LSB        = 10;
  localparam int          C_IM_MSB        = 15;

  localparam logic [31:0] C_PRID_DEFAULT  = 32'h0000_0001;

  typedef struct packed {
    logic [5:0] im;
    logic       exl;
    logic       ie;
  } sr_t;

  // Place the implemented SR fields at their architectural bit positions.
  function automatic logic [31:0] sr_word(input sr_t s);
    logic [31:0] w;
    w                    = '0;
    w[C_IM_MSB:C_IM_LSB] = s.im;
    w[C_BIT_EXL]         = s.exl;
    w[C_BIT_IE]          = s.ie;
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cp0_timer.sv
// ============================================================================
// Module   : cp0_timer
// Purpose  : Count/Compare pair with sticky timer interrupt flag TI.
// Revision : 1.0
// ============================================================================
`default_nettype none

module cp0_timer
  import cp0_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we_count,
  input  logic              we_compare,
  input  logic [C_XLEN-1:0] din,
  output logic [C_XLEN-1:0] count,
  output logic [C_XLEN-1:0] compare,
  output logic              ti
);

  logic [C_XLEN-1:0] r_count;
  logic [C_XLEN-1:0] r_compare;
  logic              r_ti;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count   <= '0;
      r_compare <= '0;
      r_ti      <= 1'b0;
    end else begin
      r_count <= we_count ? din : r_count + 1'b1;
      if (we_compare)
        r_compare <= din;
      // Clearing through a Compare write wins over a same-edge match.
      if (we_compare)
        r_ti <= 1'b0;
      else if ((r_count == r_compare) && (r_compare != '0))
        r_ti <= 1'b1;
    end
  end

  assign count   = r_count;
  assign compare = r_compare;
  assign ti      = r_ti;

endmodule

`default_nettype wire

// File: rtl/cp0_unit.sv
// ============================================================================
// Module   : cp0_unit
// Purpose  : CP0 register file (SR, Cause, EPC, PRId) and interrupt gate.
//            Optional Count/Compare timer when CP0_TIMER_EN is defined.
// Revision : 1.0
// ============================================================================
`default_nettype none

module cp0_unit
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID = C_PRID_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  a_sel,
  input  logic [31:0] din,
  input  logic        we,
  input  logic [31:0] pc,
  input  logic [5:0]  hw_int,
  input  logic        exl_set,
  input  logic        exl_clr,
  output logic [31:0] dout,
  output logic [31:0] epc,
  output logic        irq
);

  sr_t         r_sr;
  logic [5:0]  r_ip;
  logic [31:0] r_epc;

  logic        w_wr_sr;
  logic        w_wr_epc;
  logic        w_ti;
  logic [31:0] w_count;
  logic [31:0] w_compare;
  logic        w_unused_pc;

  assign w_wr_sr     = we && (a_sel == C_REG_SR);
  assign w_wr_epc    = we && (a_sel == C_REG_EPC);
  assign w_unused_pc = &{1'b0, pc[1:0]};

`ifdef CP0_TIMER_EN
  cp0_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .we_count   (we && (a_sel == C_REG_COUNT)),
    .we_compare (we && (a_sel == C_REG_COMPARE)),
    .din        (din),
    .count      (w_count),
    .compare    (w_compare),
    .ti         (w_ti)
  );
`else
  assign w_ti      = 1'b0;
  assign w_count   = '0;
  assign w_compare = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sr  <= '0;
      r_ip  <= '0;
      r_epc <= '0;
    end else begin
      r_ip <= {hw_int[5] | w_ti, hw_int[4:0]};
      if (w_wr_sr) begin
        r_sr.im <= din[C_IM_MSB:C_IM_LSB];
        r_sr.ie <= din[C_BIT_IE];
      end
      // Exception entry dominates return, which dominates a software write.
      if (exl_set)
        r_sr.exl <= 1'b1;
      else if (exl_clr)
        r_sr.exl <= 1'b0;
      else if (w_wr_sr)
        r_sr.exl <= din[C_BIT_EXL];
      if (exl_set)
        r_epc <= {pc[31:2], 2'b00};
      else if (w_wr_epc)
        r_epc <= din;
    end
  end

  assign irq = r_sr.ie & ~r_sr.exl & (|(r_ip & r_sr.im));
  assign epc = r_epc;

  always_comb begin
    dout = '0;
    case (a_sel)
      C_REG_COUNT:   dout = w_count;
      C_REG_COMPARE: dout = w_compare;
      C_REG_SR:      dout = sr_word(r_sr);
      C_REG_CAUSE:   dout[C_IM_MSB:C_IM_LSB] = r_ip;
      C_REG_EPC:     dout = r_epc;
      C_REG_PRID:    dout = PRID;
      default:       dout = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: doc/cp0_unit.md
# cp0_unit

Coprocessor-0 register file and interrupt gate for the multicycle MIPS core. Consumes the controller's `cp0Wr`, `EXLSet` and `EXLClr` strobes and the `mfc0`/`mtc0` register select. Produces the `irq` request the controller samples in its interrupt state, and the EPC target used on `eret`. It holds SR, Cause, EPC and PRId, and latches external interrupt lines.

## Interface
- `PRID`, default 32'h0000_0001: value returned for register 15.
- `clk` in 1: clock, all state updates on posedge.
- `rst` in 1: reset, asynchronous, active-high.
- `a_sel` in 5: CP0 register number (instruction rd field) for read and write.
- `din` in 32: `mtc0` write data (GPR rt).
- `we` in 1: write strobe (controller `cp0Wr`).
- `pc` in 32: return address captured into EPC on exception entry.
- `hw_int` in 6: external interrupt lines, level-sensitive.
- `exl_set` in 1: exception entry (controller `EXLSet`).
- `exl_clr` in 1: exception return (controller `EXLClr`).
- `dout` out 32: read data for `a_sel`, combinational.
- `epc` out 32: current EPC, registered.
- `irq` out 1: interrupt request to controller.

## Operation
- **SR (reg 12)**
  - Bits [15:10] are IM, bit [1] is EXL, bit [0] is IE.
  - All other bits read 0 and ignore writes.
- **Cause (reg 13)**
  - Bits [15:10] are IP, read-only.
  - Every cycle, IP <= hw_int. When the timer is enabled, IP[15] <= hw_int[5] | TI.
  - All other bits read 0. Writes are ignored.
- **EPC (reg 14)**
  - Writable by `we`.
  - On `exl_set`, EPC <= {pc[31:2], 2'b00}.
- **PRId (reg 15)**: constant `PRID`; writes are ignored.
- **Unimplemented registers** read 32'h0 and ignore writes.
- **irq** = SR.IE & ~SR.EXL & |(IP & IM). Combinational from registered state only.
- **EXL update priority**: `exl_set` > `exl_clr` > `we` to SR.
  - If `exl_set` and `we` to SR occur in the same cycle, IM and IE take `din`, and EXL ends at 1.
- **EPC update priority**: `exl_set` beats `we` to EPC.
- **Reset values**:
  - SR, Cause, EPC, Count, Compare and TI are all 0.
  - Therefore `irq` = 0, `epc` = 0, and `dout` = 0 except when `a_sel` is 15.
- Reset asserted mid-operation clears all state immediately (asynchronous). A pending interrupt is lost.

## Timing
- **Writes**: take effect at the posedge where `we` is high. `dout` shows the new value in the following cycle.
- **Reads**: `dout` has zero latency from `a_sel`.
- **Interrupt latency**: `hw_int` high at posedge N gives IP set after N, so `irq` is high in cycle N+1 if unmasked.
  - Dropping `hw_int` clears IP and `irq` one edge later. Lines are not sticky.
- **Exception entry**: `exl_set` at edge N gives EXL = 1 after N, so `irq` = 0 from cycle N+1. This blocks re-entry.
- **Exception return**: `exl_clr` at edge N gives EXL = 0 after N, so `irq` can reassert in cycle N+1.

## Configuration
- **`CP0_TIMER_EN` defined**: adds Count (reg 9) and Compare (reg 11).
  - Count increments every cycle, wrapping from 32'hFFFF_FFFF to 0.
  - A `we` to Count loads `din` at that edge, replacing the increment.
  - TI sets at the edge after Count == Compare, provided Compare != 0. TI is sticky.
  - A `we` to Compare clears TI; if both occur at the same edge, the clear wins.
  - TI feeds IP[15].
- **`CP0_TIMER_EN` undefined**: regs 9 and 11 read 0 and ignore writes. TI does not exist. IP[15] = hw_int[5] only.

## Structure
- **Package `cp0_pkg`** holds:
  - register index constants (9, 11, 12, 13, 14, 15);
  - SR/Cause bit positions (IE=0, EXL=1, IM/IP=[15:10]);
  - the PRID default.
- **Sub-module `cp0_timer`** holds Count, Compare and TI. It is instantiated only under `CP0_TIMER_EN`. Its interface is `clk`, `rst`, `we_count`, `we_compare`, `din`, `count`, `compare`, `ti`.

## Test plan
- **Reset**: assert `rst` mid-run with EXL=1 and IM=6'h3F. Require `irq`=0, `epc`=0, reg 12 reads 0, and reg 15 reads `PRID`.
- **Interrupt path**:
  - Write SR=32'h0000_0401 and hold hw_int=6'b000001. Require `irq`=1 one cycle after the sampling edge.
  - With hw_int=6'b000010 and the same SR, require `irq`=0 (masked).
- **Exception entry and return**:
  - With `irq`=1, pulse `exl_set` with pc=32'h0000_3007. Require EPC=32'h0000_3004, reg 12 = 32'h0000_0403, and `irq`=0 next cycle.
  - Then pulse `exl_clr`. Require EXL=0 and `irq`=1 again.
- **Simultaneous events**:
  - `exl_set` with `we` to SR (din=0). Require SR = 32'h0000_0002.
  - `exl_set` with `we` to EPC (din=32'h1234). Require EPC = pc aligned.
- **Read-only and unimplemented registers**: write 32'hFFFF_FFFF to regs 13, 15 and 20. Require they read 0, `PRID` and 0 respectively.
- **Timer (`CP0_TIMER_EN`)**:
  - Write Compare=10 and Count=5, set IM[15] and IE. Require TI and `irq` = 1 six cycles after the Count write.
  - Write Compare again. Require TI=0.
  - Load Count=32'hFFFF_FFFE. Require it reads 0 two cycles later.
